// File: rtl/u8_ccc_pkg.sv
// Shared types and constants for the u8_ccc clock-enable generator.
// The optional U8_CCC_LOSS_CNT_EN build uses LOSS_CNT_W for its loss counter width.
package u8_ccc_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } ccc_state_t;

  localparam int unsigned LOSS_CNT_W = 8;

  // Cycles from the first LOCKED-high cycle (counted as 1) to the first CE, inclusive.
  function automatic int unsigned first_ce_latency(input int unsigned acc_w,
                                                   input longint unsigned inc);
    longint unsigned span;
    span = 64'd1 << acc_w;
    if (inc == 0) return 0;
    return 32'(((span + inc - 64'd1) / inc) + 64'd1);
  endfunction

endpackage

// File: rtl/u8_ccc_phase_acc.sv
// One channel of the clock-enable generator: phase accumulator, registered
// carry output and the logic that swaps in a pending increment at a wrap.
module u8_ccc_phase_acc
  import u8_ccc_pkg::*;
#(
  parameter int unsigned        ACC_W   = 24,
  parameter logic [ACC_W-1:0]   INC_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             lock_ok,
  input  logic             pend_hit,
  input  logic [ACC_W-1:0] pend_inc,
  output logic             apply,
  output logic             ce,
  output logic [ACC_W-1:0] inc
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             carry;

  // The carry still counts on the lock-loss cycle so a pending apply completes,
  // while the CE itself is suppressed by lock_ok.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, inc};
    carry = run & sum[ACC_W];
    apply = pend_hit & (~run | (inc == '0) | carry);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      ce  <= 1'b0;
      inc <= INC_RST;
    end else begin
      if (run && lock_ok) begin
        acc <= sum[ACC_W-1:0];
        ce  <= carry;
      end else begin
        acc <= '0;
        ce  <= 1'b0;
      end
      if (apply) inc <= pend_inc;
    end
  end

endmodule

// File: rtl/u8_ccc_ce_gen.sv
// Multi-channel fractional clock-enable generator gated by a settle-qualified PLL lock.
// Defining U8_CCC_LOSS_CNT_EN adds the LOSS_CNT / LOSS_STICKY lock-loss monitors.
module u8_ccc_ce_gen
  import u8_ccc_pkg::*;
#(
  parameter int unsigned      NUM_CH     = 4,
  parameter int unsigned      ACC_W      = 24,
  parameter int unsigned      SETTLE_CYC = 1024,
  parameter logic [ACC_W-1:0] INC_RST    = '0,
  localparam int unsigned     CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    CLK0,
  input  logic                    RESET_N,
  input  logic                    PLL_LOCK,
  input  logic                    CFG_VALID,
  output logic                    CFG_READY,
  input  logic [CH_W-1:0]         CFG_CH,
  input  logic [ACC_W-1:0]        CFG_INC,
  output logic [NUM_CH-1:0]       CE,
  output logic                    LOCKED,
  output logic [NUM_CH*ACC_W-1:0] CH_INC_RD
`ifdef U8_CCC_LOSS_CNT_EN
  ,
  output logic [LOSS_CNT_W-1:0]   LOSS_CNT,
  output logic                    LOSS_STICKY
`endif
);

  localparam int unsigned      CNT_W       = $clog2(SETTLE_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  ccc_state_t       state;
  logic [CNT_W-1:0] settle_cnt;
  logic             lock_meta;
  logic             lock_s;
  logic             run;

  logic             pend_valid;
  logic             pend_oob;
  logic [CH_W-1:0]  pend_ch;
  logic [ACC_W-1:0] pend_inc;
  logic [NUM_CH-1:0] apply;
  logic [ACC_W-1:0] inc_q [NUM_CH];

  always_ff @(posedge CLK0) begin
    if (!RESET_N) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= PLL_LOCK;
      lock_s    <= lock_meta;
    end
  end

  // LOCKED is loaded with the next-state decode so it lines up with state==RUN.
  always_ff @(posedge CLK0) begin
    if (!RESET_N) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      LOCKED     <= 1'b0;
    end else begin
      unique case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (settle_cnt == SETTLE_LAST) begin
            state  <= RUN;
            LOCKED <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_s) begin
            state  <= WAIT_LOCK;
            LOCKED <= 1'b0;
          end
        end
        default: begin
          state  <= WAIT_LOCK;
          LOCKED <= 1'b0;
        end
      endcase
    end
  end

  assign run = (state == RUN);

  if (NUM_CH < (1 << CH_W)) begin : g_oob
    assign pend_oob = (32'(pend_ch) >= NUM_CH);
  end else begin : g_no_oob
    assign pend_oob = 1'b0;
  end

  always_ff @(posedge CLK0) begin
    if (!RESET_N) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_inc   <= '0;
    end else if (pend_valid) begin
      if (pend_oob || (apply != '0)) pend_valid <= 1'b0;
    end else if (CFG_VALID) begin
      pend_valid <= 1'b1;
      pend_ch    <= CFG_CH;
      pend_inc   <= CFG_INC;
    end
  end

  assign CFG_READY = ~pend_valid;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    u8_ccc_phase_acc #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_RST)
    ) u_acc (
      .clk      (CLK0),
      .rst_n    (RESET_N),
      .run      (run),
      .lock_ok  (lock_s),
      .pend_hit (pend_valid && (pend_ch == CH_W'(i))),
      .pend_inc (pend_inc),
      .apply    (apply[i]),
      .ce       (CE[i]),
      .inc      (inc_q[i])
    );
    assign CH_INC_RD[i*ACC_W +: ACC_W] = inc_q[i];
  end

`ifdef U8_CCC_LOSS_CNT_EN
  always_ff @(posedge CLK0) begin
    if (!RESET_N) begin
      LOSS_CNT    <= '0;
      LOSS_STICKY <= 1'b0;
    end else if (run && !lock_s) begin
      LOSS_STICKY <= 1'b1;
      if (LOSS_CNT != '1) LOSS_CNT <= LOSS_CNT + LOSS_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_u8_ccc_ce_gen.sv
// Self-checking bench for u8_ccc_ce_gen: vector table, hand sequences for
// settle / rate / update / lock-loss corners, then randomized traffic vs a model.
module tb_u8_ccc_ce_gen;
  import u8_ccc_pkg::*;

  // NUM_CH=3 so a 2-bit CFG_CH can address a nonexistent channel (3).
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned ACC_W      = 8;
  localparam int unsigned SETTLE_CYC = 16;
  localparam int unsigned CH_W       = 2;
  localparam int unsigned SPAN       = 1 << ACC_W;

  logic                    CLK0      = 1'b0;
  logic                    RESET_N   = 1'b0;
  logic                    PLL_LOCK  = 1'b0;
  logic                    CFG_VALID = 1'b0;
  logic [CH_W-1:0]         CFG_CH    = '0;
  logic [ACC_W-1:0]        CFG_INC   = '0;
  logic                    CFG_READY;
  logic [NUM_CH-1:0]       CE;
  logic                    LOCKED;
  logic [NUM_CH*ACC_W-1:0] CH_INC_RD;
`ifdef U8_CCC_LOSS_CNT_EN
  logic [7:0]              LOSS_CNT;
  logic                    LOSS_STICKY;
`endif

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;

  always #5 CLK0 = ~CLK0;

  u8_ccc_ce_gen #(
    .NUM_CH     (NUM_CH),
    .ACC_W      (ACC_W),
    .SETTLE_CYC (SETTLE_CYC),
    .INC_RST    (8'd0)
  ) dut (
    .CLK0      (CLK0),
    .RESET_N   (RESET_N),
    .PLL_LOCK  (PLL_LOCK),
    .CFG_VALID (CFG_VALID),
    .CFG_READY (CFG_READY),
    .CFG_CH    (CFG_CH),
    .CFG_INC   (CFG_INC),
    .CE        (CE),
    .LOCKED    (LOCKED),
    .CH_INC_RD (CH_INC_RD)
`ifdef U8_CCC_LOSS_CNT_EN
    ,
    .LOSS_CNT    (LOSS_CNT),
    .LOSS_STICKY (LOSS_STICKY)
`endif
  );

  // Reference model: lock qualification as a run length of synchronised-high
  // samples, phases as plain integers modulo 2^ACC_W, the slot as a flag.
  logic              m_meta, m_ls, m_run;
  int unsigned       m_r;
  int unsigned       m_phase [NUM_CH];
  int unsigned       m_inc   [NUM_CH];
  logic [NUM_CH-1:0] m_ce;
  logic              m_pend;
  int unsigned       m_pch, m_pinc;

  task automatic model_edge();
    logic ls, run;
    int unsigned tot;
    logic [NUM_CH-1:0] carry;
    if (!RESET_N) begin
      m_meta = 1'b0; m_ls = 1'b0; m_run = 1'b0; m_r = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        m_phase[i] = 0; m_inc[i] = 0;
      end
      m_ce = '0; m_pend = 1'b0; m_pch = 0; m_pinc = 0;
      return;
    end
    ls  = m_ls;
    run = m_run;
    for (int i = 0; i < NUM_CH; i++) begin
      tot      = m_phase[i] + m_inc[i];
      carry[i] = run && (tot >= SPAN);
      if (run && ls) begin
        m_phase[i] = tot % SPAN;
        m_ce[i]    = carry[i];
      end else begin
        m_phase[i] = 0;
        m_ce[i]    = 1'b0;
      end
    end
    if (m_pend) begin
      if (m_pch >= NUM_CH) m_pend = 1'b0;
      else if (m_inc[m_pch] == 0 || !run || carry[m_pch]) begin
        m_inc[m_pch] = m_pinc;
        m_pend       = 1'b0;
      end
    end else if (CFG_VALID) begin
      m_pend = 1'b1; m_pch = CFG_CH; m_pinc = CFG_INC;
    end
    m_r    = ls ? ((m_r > SETTLE_CYC) ? m_r : m_r + 1) : 0;
    m_run  = (m_r >= SETTLE_CYC + 1);
    m_ls   = m_meta;
    m_meta = PLL_LOCK;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_all();
    logic [NUM_CH*ACC_W-1:0] exp_rd;
    for (int i = 0; i < NUM_CH; i++) exp_rd[i*ACC_W +: ACC_W] = ACC_W'(m_inc[i]);
    chk("model_ce",     64'(CE),        64'(m_ce));
    chk("model_locked", 64'(LOCKED),    64'(m_run));
    chk("model_ready",  64'(CFG_READY), 64'(!m_pend));
    chk("model_inc_rd", 64'(CH_INC_RD), 64'(exp_rd));
  endtask

  task automatic cycle();
    @(posedge CLK0);
    model_edge();
    @(negedge CLK0);
    cyc++;
    check_all();
  endtask

  task automatic cfg_write(input int unsigned ch, input int unsigned inc);
    logic rdy;
    logic done;
    done = 1'b0;
    CFG_CH    = CH_W'(ch);
    CFG_INC   = ACC_W'(inc);
    CFG_VALID = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      rdy = CFG_READY;
      cycle();
      done = rdy;
    end
    CFG_VALID = 1'b0;
    chk("cfg_write_accepted", 64'(done), 64'd1);
  endtask

  task automatic wait_ce0(output int unsigned at);
    logic found;
    found = 1'b0;
    at    = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      cycle();
      if (CE[0]) begin
        found = 1'b1;
        at    = cyc;
      end
    end
    chk("wait_ce0_timeout", 64'(found), 64'd1);
  endtask

  typedef struct {
    int unsigned ch;
    int unsigned inc;
    logic [23:0] exp_rd;
  } cfg_vec_t;

  cfg_vec_t vecs [5];

  initial begin
    int unsigned n, t, first0, first1, t0, t1, t2;
    logic early, e0, e1;

    vecs[0] = '{ch: 0, inc: 64,  exp_rd: 24'h000040};
    vecs[1] = '{ch: 1, inc: 96,  exp_rd: 24'h006040};
    vecs[2] = '{ch: 2, inc: 255, exp_rd: 24'hFF6040};
    vecs[3] = '{ch: 3, inc: 17,  exp_rd: 24'hFF6040};
    vecs[4] = '{ch: 2, inc: 0,   exp_rd: 24'h006040};

    // Reset state
    RESET_N = 1'b0;
    repeat (3) cycle();
    chk("rst_ce",     64'(CE),        64'd0);
    chk("rst_locked", 64'(LOCKED),    64'd0);
    chk("rst_ready",  64'(CFG_READY), 64'd1);
    chk("rst_inc_rd", 64'(CH_INC_RD), 64'd0);
    RESET_N = 1'b1;
    cycle();

    // Writes while unlocked apply on the cycle after acceptance
    for (int v = 0; v < 5; v++) begin
      cfg_write(vecs[v].ch, vecs[v].inc);
      chk("vec_ready_low", 64'(CFG_READY), 64'd0);
      cycle();
      chk("vec_ready_back", 64'(CFG_READY), 64'd1);
      chk("vec_inc_rd",     64'(CH_INC_RD), 64'(vecs[v].exp_rd));
    end

    // Settle: LOCKED 2 sync + 16 settle + 1 cycles after PLL_LOCK
    PLL_LOCK = 1'b1;
    n = 0; early = 1'b0;
    while (!LOCKED && n < 200) begin
      cycle();
      n++;
      if (!LOCKED && CE != '0) early = 1'b1;
    end
    chk("settle_latency", 64'(n), 64'(2 + SETTLE_CYC + 1));
    chk("no_early_ce",    64'(early), 64'd0);

    // Rate: CE when floor(adds*inc/2^W) steps; t=1 is the first LOCKED cycle
    first0 = 0; first1 = 0;
    for (t = 1; t <= 32; t++) begin
      e0 = (t >= 2) && (((t - 1) * 64) / SPAN > ((t - 2) * 64) / SPAN);
      e1 = (t >= 2) && (((t - 1) * 96) / SPAN > ((t - 2) * 96) / SPAN);
      chk("rate_ce0", 64'(CE[0]), 64'(e0));
      chk("rate_ce1", 64'(CE[1]), 64'(e1));
      if (CE[0] && first0 == 0) first0 = t;
      if (CE[1] && first1 == 0) first1 = t;
      cycle();
    end
    chk("first_ce0_lat", 64'(first0), 64'(first_ce_latency(ACC_W, 64)));
    chk("first_ce1_lat", 64'(first1), 64'(first_ce_latency(ACC_W, 96)));

    // Glitch-free update 64 -> 32 requested mid-period
    wait_ce0(t0);
    cycle();
    cycle();
    cfg_write(0, 32);
    chk("upd_ready_low", 64'(CFG_READY), 64'd0);
    wait_ce0(t1);
    chk("upd_old_period", 64'(t1 - t0), 64'd4);
    chk("upd_ready_back", 64'(CFG_READY), 64'd1);
    chk("upd_inc_rd",     64'(CH_INC_RD), 64'h006020);
    wait_ce0(t2);
    chk("upd_new_period", 64'(t2 - t1), 64'd8);

    // One-cycle lock drop
    PLL_LOCK = 1'b0;
    cycle();
    PLL_LOCK = 1'b1;
    n = 0;
    while (LOCKED && n < 10) begin cycle(); n++; end
    chk("loss_fall_delay", 64'(n), 64'd2);
    chk("loss_ce_zero",    64'(CE), 64'd0);
    n = 0;
    while (!LOCKED && n < 100) begin cycle(); n++; end
    chk("relock_delay",   64'(n), 64'(SETTLE_CYC + 1));
    chk("relock_inc_rd",  64'(CH_INC_RD), 64'h006020);
    t = 1;
    while (!CE[0] && t < 40) begin cycle(); t++; end
    chk("relock_first_ce0", 64'(t), 64'(first_ce_latency(ACC_W, 32)));

    // Stopped channel in RUN takes a new rate at once
    cfg_write(2, 64);
    chk("zero_inc_ready_low", 64'(CFG_READY), 64'd0);
    cycle();
    chk("zero_inc_ready_back", 64'(CFG_READY), 64'd1);
    chk("zero_inc_rd",         64'(CH_INC_RD), 64'h406020);

    // Reset while an update is pending drops it
    wait_ce0(t0);
    cfg_write(0, 128);
    chk("rstpend_ready_low", 64'(CFG_READY), 64'd0);
    cycle();
    chk("rstpend_still_pending", 64'(CFG_READY), 64'd0);
    RESET_N = 1'b0;
    cycle();
    chk("rstpend_ready",  64'(CFG_READY), 64'd1);
    chk("rstpend_inc_rd", 64'(CH_INC_RD), 64'd0);
    chk("rstpend_locked", 64'(LOCKED),    64'd0);
    RESET_N = 1'b1;
    repeat (10) cycle();
    chk("rstpend_no_apply", 64'(CH_INC_RD), 64'd0);
    chk("rstpend_ready2",   64'(CFG_READY), 64'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      RESET_N   = ($urandom_range(0, 999) != 0);
      PLL_LOCK  = ($urandom_range(0, 99) != 0);
      CFG_VALID = ($urandom_range(0, 3) == 0);
      CFG_CH    = CH_W'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       CFG_INC = '0;
        1:       CFG_INC = '1;
        2:       CFG_INC = ACC_W'($urandom_range(1, 8));
        default: CFG_INC = ACC_W'($urandom);
      endcase
      cycle();
    end
    RESET_N = 1'b1; CFG_VALID = 1'b0; PLL_LOCK = 1'b0;

`ifdef U8_CCC_LOSS_CNT_EN
    RESET_N = 1'b0;
    cycle();
    RESET_N = 1'b1;
    chk("loss_rst_cnt",    64'(LOSS_CNT),    64'd0);
    chk("loss_rst_sticky", 64'(LOSS_STICKY), 64'd0);
    for (int k = 0; k < 300; k++) begin
      PLL_LOCK = 1'b1;
      n = 0;
      while (!LOCKED && n < 40) begin cycle(); n++; end
      PLL_LOCK = 1'b0;
      n = 0;
      while (LOCKED && n < 10) begin cycle(); n++; end
    end
    chk("loss_cnt_sat", 64'(LOSS_CNT),    64'd255);
    chk("loss_sticky",  64'(LOSS_STICKY), 64'd1);
    RESET_N = 1'b0;
    cycle();
    RESET_N = 1'b1;
    chk("loss_cnt_clr",    64'(LOSS_CNT),    64'd0);
    chk("loss_sticky_clr", 64'(LOSS_STICKY), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
